// File: rtl/alu_pkg.sv
// alu_pkg: opcode and state encodings shared by the alu_mc datapath and its multiplier.
package alu_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_AND    = 4'h0,
      OP_XOR    = 4'h1,
      OP_OR     = 4'h2,
      OP_SHL    = 4'h3,
      OP_SHR    = 4'h4,
      OP_ADD    = 4'h5,
      OP_SUB    = 4'h6,
      OP_LTU    = 4'h7,
      OP_GTU    = 4'h8,
      OP_EQ     = 4'h9,
      OP_SUBC   = 4'hA,
      OP_LTS    = 4'hB,
      OP_GTS    = 4'hC,
      OP_MUL    = 4'hD,
      OP_PASS_E = 4'hE,
      OP_PASS_F = 4'hF
   } alu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one multiplier bit per cycle.
// start loads the operands; done is high on the cycle whose edge completes the product.
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 run,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNTW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0]   a_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH:0]     partial;
   logic [CNTW-1:0]    cnt_q;

   // Upper half accumulates the multiplicand; lower half shifts the multiplier out LSB first.
   always_comb begin
      partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
      acc_nxt = {partial, acc_q[WIDTH-1:1]};
   end

   assign done    = run && (cnt_q == CNTW'(WIDTH - 1));
   assign product = acc_nxt;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // independent of statement order within the block.
      if (!reset_n) begin
         a_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         a_q   <= a;
         acc_q <= {{WIDTH{1'b0}}, b};
         cnt_q <= '0;
      end else if (run) begin
         acc_q <= acc_nxt;
         cnt_q <= done ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered ALU, valid/ready in and out, one-entry output register.
// Define ALU_MC_MUL_EN to add the iterative multiply (opcode D); otherwise D is pass-through.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rslt,
   output logic [WIDTH-1:0] rslt_hi,
   output logic             carry_out,
   output logic             branch_flag,
   output logic             busy
);

   alu_state_e       state;
   alu_op_e          op;
   logic             accept;
   logic             out_xfer;
   logic             start_mul;
   logic [WIDTH-1:0] res;
   logic             res_co;
   logic             res_bf;
   logic [WIDTH:0]   subc_ext;

   assign op       = alu_op_e'(ALU_OP_W'(alu_op));
   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path infers a latch.
      res      = '0;
      res_co   = 1'b0;
      res_bf   = 1'b0;
      subc_ext = '0;
      case (op)
         OP_AND: res = in_a & in_b;
         OP_XOR: res = in_a ^ in_b;
         OP_OR:  res = in_a | in_b;
         OP_SHL: begin
            res    = {in_a[WIDTH-2:0], carry_in};
            res_co = in_a[WIDTH-1];
         end
         OP_SHR: begin
            res    = {1'b0, in_a[WIDTH-1:1]};
            res_co = in_a[0];
         end
         OP_ADD: begin
            res    = in_a + in_b;
            res_co = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SUB: begin
            res    = in_a - in_b;
            res_co = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_LTU: res_bf = in_a < in_b;
         OP_GTU: res_bf = in_a > in_b;
         OP_EQ:  res_bf = in_a == in_b;
         OP_LTS: res_bf = $signed(in_a) < $signed(in_b);
         OP_GTS: res_bf = $signed(in_a) > $signed(in_b);
         OP_SUBC: begin
            subc_ext = {1'b0, in_a} - {1'b0, in_b} + {{WIDTH{1'b0}}, carry_in};
            res      = subc_ext[WIDTH-1:0];
            res_co   = subc_ext[WIDTH];
         end
         default: res = in_a;
      endcase
   end

`ifdef ALU_MC_MUL_EN
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign start_mul = accept && (op == OP_MUL);
   assign busy      = (state == MUL);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start_mul),
      .run     (state == MUL),
      .a       (in_a),
      .b       (in_b),
      .done    (mul_done),
      .product (mul_prod)
   );
`else
   assign start_mul = 1'b0;
   assign busy      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         out_valid   <= 1'b0;
         rslt        <= '0;
         rslt_hi     <= '0;
         carry_out   <= 1'b0;
         branch_flag <= 1'b0;
      end else begin
         // A load below overrides this clear, giving one result per cycle under back-pressure-free flow.
         if (out_xfer) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start_mul) begin
                  state <= MUL;
               end else if (accept) begin
                  rslt        <= res;
                  rslt_hi     <= '0;
                  carry_out   <= res_co;
                  branch_flag <= res_bf;
                  out_valid   <= 1'b1;
               end
            end
`ifdef ALU_MC_MUL_EN
            MUL: begin
               if (mul_done) begin
                  state       <= IDLE;
                  rslt        <= mul_prod[WIDTH-1:0];
                  rslt_hi     <= mul_prod[2*WIDTH-1:WIDTH];
                  carry_out   <= 1'b0;
                  branch_flag <= 1'b0;
                  out_valid   <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
